// File: rtl/mcp_rx_buffer.sv
// Destination-side consumer for an MCP receiver: retires words with a one-cycle
// load pulse and buffers them in a small FWFT FIFO presented as a valid/ready stream.
module mcp_rx_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                       bclk,
    input  logic                       brst_n,
    input  logic                       mcp_bvalid,
    input  logic [DW-1:0]              mcp_bdata,
    output logic                       mcp_bload,
    output logic                       out_valid,
    output logic [DW-1:0]              out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic [CW-1:0]              word_cnt
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);
    localparam logic [PW-1:0]   PTR_INC = PW'(1);
    localparam logic [CW-1:0]   WC_INC  = CW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t          state_r;
    logic [DW-1:0]   mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CNTW-1:0] count_r;
    logic [CNTW-1:0] count_nxt_s;
    logic            full_r;
    logic            empty_r;
    logic [CW-1:0]   word_cnt_r;
    logic            push_s;
    logic            pop_s;

    // Load decision and next occupancy; load is held off during reset and uses registered full only.
    always_comb begin
        push_s      = brst_n && (state_r == S_IDLE) && mcp_bvalid && !full_r;
        pop_s       = !empty_r && out_ready;
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + ONE_C;
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - ONE_C;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Load FSM: S_HOLD masks the receiver's one-cycle lag in dropping mcp_bvalid.
    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) begin
            state_r <= S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:  state_r <= push_s ? S_HOLD : S_IDLE;
                S_HOLD:  state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // FIFO storage, pointers and registered occupancy flags.
    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= mcp_bdata;
                wr_ptr_r        <= wr_ptr_r + PTR_INC;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_INC;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_C);
            empty_r <= (count_nxt_s == '0);
        end
    end

    // Retired-word counter, wraps silently.
    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) begin
            word_cnt_r <= '0;
        end else if (push_s) begin
            word_cnt_r <= word_cnt_r + WC_INC;
        end
    end

    assign mcp_bload = push_s;
    assign out_valid = !empty_r;
    assign out_data  = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign word_cnt  = word_cnt_r;

endmodule

// File: doc/mcp_rx_buffer.md
Name: mcp_rx_buffer

Overview:
- Destination-domain consumer that sits directly downstream of the multi-cycle-path (MCP) receive block.
- Watches the receiver's data-valid flag and issues the single-cycle load pulse that retires each word; the load pulse also triggers the acknowledge back to the sender.
- Captures each retired word into a small first-word-fall-through (FWFT) FIFO and presents it as a valid/ready stream to local logic.
- Back-pressure propagates to the sender by withholding the load pulse. No data is ever dropped.

Parameters:
- DW, 8, data word width; must match the MCP receiver's data width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 16, width of the retired-word counter.

Ports:
- bclk  input  1  destination-domain clock.
- brst_n  input  1  asynchronous active-low reset.
- mcp_bvalid  input  1  receiver holds a valid, unloaded word.
- mcp_bdata  input  DW  receiver data word; stable while mcp_bvalid=1.
- mcp_bload  output  1  single-cycle load/retire pulse to the receiver.
- out_valid  output  1  out_data holds the FIFO head.
- out_data  output  DW  FIFO head word.
- out_ready  input  1  downstream accepts the head this cycle.
- count  output  $clog2(DEPTH+1)  current FIFO occupancy.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- word_cnt  output  CW  total words retired since reset; wraps modulo 2^CW.

Behaviour:
- Clock and reset:
  - Single clock bclk.
  - brst_n asserted asynchronously clears all state.
  - Reset values: mcp_bload=0, out_valid=0, out_data=0, count=0, full=0, empty=1, word_cnt=0, FSM=S_IDLE, read/write pointers=0.
- Load FSM has two states:
  - S_IDLE:
    - mcp_bload = mcp_bvalid & ~full. This is combinational from mcp_bvalid and registered full.
    - If mcp_bload=1, write mcp_bdata at the write pointer on that edge and go to S_HOLD.
  - S_HOLD:
    - mcp_bload=0 unconditionally.
    - Return to S_IDLE next cycle.
    - Purpose: mask the receiver's one-cycle lag in dropping mcp_bvalid after a load, so one word is never loaded twice.
  - Consequence: maximum accept rate is one word per 2 bclk cycles. This is always faster than the MCP round trip.
- Full gating:
  - full is the registered value.
  - A pop in the same cycle does not free space for a load in that cycle (no pop-to-push bypass).
  - A load may occur in the cycle after the pop.
- FIFO:
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally at DEPTH.
  - Push = mcp_bload. Pop = out_valid & out_ready.
  - count updates as follows:
    - +1 on push only.
    - −1 on pop only.
    - Unchanged on simultaneous push and pop.
  - Push when full is impossible by construction. Pop when empty is impossible (out_valid=0).
- Output, FWFT:
  - out_valid = ~empty, derived from registered count.
  - out_data = memory[read pointer]; it is 0 at reset until the first write.
  - Latency: word loaded at edge N → out_valid=1 and out_data=word after edge N, i.e. visible in cycle N+1.
  - out_data is stable while out_valid=1 and out_ready=0.
  - Write into an empty FIFO concurrent with no pop: head appears the next cycle.
- word_cnt:
  - Increments by 1 on every mcp_bload.
  - Wraps from 2^CW−1 to 0 with no sticky flag.
- Reset mid-operation:
  - brst_n low during S_HOLD or with data buffered discards all buffered words.
  - FSM returns to S_IDLE with mcp_bload=0 within the same reset assertion.
  - The MCP pair is reset together with this block, so no partial handshake survives.
- mcp_bdata is sampled only on the mcp_bload edge; its value at all other times is ignored.

Test Plan:
- Reset state: hold brst_n=0 with mcp_bvalid=1 → mcp_bload=0, empty=1, count=0, word_cnt=0. Release reset → first mcp_bload pulse on the first edge with mcp_bvalid=1.
- Single word: mcp_bvalid=1 and mcp_bdata=8'hA5 for 2 cycles, out_ready=1 → exactly one mcp_bload pulse, out_valid=1 with out_data=8'hA5 the next cycle, count returns to 0 after the pop, word_cnt=1.
- Fill and back-pressure:
  - Stimulus: out_ready=0, upstream offers 8'h01..8'h06 (a new word 3 cycles after each load).
  - Required: 4 loads, then full=1 and mcp_bload stays 0 while mcp_bvalid=1.
  - Then raise out_ready=1 → outputs 01,02,03,04 in order, then 05,06 loaded and output. No loss, no duplication.
- Stuck valid: mcp_bvalid held at 1 continuously with out_ready=1 → mcp_bload pulses at most every other cycle (S_HOLD masking).
- Simultaneous push and pop at count=2 → count stays 2. Data order preserved across read/write pointer wrap; run 10 words through DEPTH=4 and check the output sequence is identical to the input.
- Counter wrap and mid-reset:
  - CW=4: push 17 words → word_cnt=1.
  - Assert brst_n for 1 cycle while count=3 and FSM=S_HOLD → all outputs return to reset values, and the next offered word is the first output word.
